sweep_scheduler: RTL and testbench
==================================

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

Interface
REQ-001 Parameter WATCHDOG_CYCLES, default 24'd16_000_000: maximum cycles to wait for sweep_done before abandoning a sweep job.
REQ-002 Parameter PLL_DWELL_CYCLES, default 24'd5_000_000: cycles a PLL-mode job owns the sweeper before release.
REQ-003 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester job request, level; held until grant.
REQ-006 req_mode  input  2  per-requester mode, 0 = sweep, 1 = PLL.
REQ-007 req_init_freq0 / req_init_freq1  input  32  start frequency tuning word.
REQ-008 req_cycles0 / req_cycles1  input  16  cycles per step.
REQ-009 req_step0 / req_step1  input  32  frequency step word.
REQ-010 grant  output  2  one-hot, one-cycle pulse: request accepted and operands latched.
REQ-011 reject  output  2  one-hot, one-cycle pulse: request refused (invalid operands).
REQ-012 job_done  output  2  one-hot, one-cycle pulse: owner's job finished normally.
REQ-013 job_timeout  output  2  one-hot, one-cycle pulse: owner's sweep job abandoned by watchdog.
REQ-014 busy  output  1  high from grant through job_done/job_timeout.
REQ-015 fifo_full  input  1  instruction FIFO full.
REQ-016 fifo_wr_en  output  1  one-cycle write strobe.
REQ-017 fifo_wdata  output  88  instruction word.
REQ-018 sweep_done  input  1  completion pulse from the sweeper.

Function
REQ-019 Instruction packing: bit 87 = mode, [86:80] = 0, [79:48] = init_freq, [47:32] = cycles, [31:0] = step.
REQ-020 States: IDLE, WRITE, WAIT_SWEEP, WAIT_PLL; exactly one job in flight.
REQ-021 IDLE: if req != 0, select owner round-robin (requester not granted last wins ties; after reset requester 0 wins ties).
REQ-022 Validation in IDLE: sweep-mode request with cycles == 0 -> reject pulse, last-granted pointer unchanged, stay IDLE; PLL mode does no validation.
REQ-023 Valid request: grant pulse to owner in the selection cycle, latch its operands, busy = 1, next state WRITE.
REQ-024 WRITE: while fifo_full = 1, hold with fifo_wr_en = 0; first cycle with fifo_full = 0, fifo_wr_en = 1 for exactly one cycle with the packed word.
REQ-025 After the write: mode 0 -> WAIT_SWEEP, mode 1 -> WAIT_PLL; 24-bit wait counter cleared.
REQ-026 WAIT_SWEEP: sweep_done = 1 -> job_done to owner next cycle, busy = 0, IDLE; otherwise counter increments.
REQ-027 WAIT_SWEEP: counter reaches WATCHDOG_CYCLES - 1 with no sweep_done -> job_timeout to owner, IDLE; sweep_done in that same cycle takes priority (job_done).
REQ-028 WAIT_PLL: after PLL_DWELL_CYCLES cycles, job_done to owner, IDLE; sweep_done ignored.
REQ-029 sweep_done outside WAIT_SWEEP is ignored.
REQ-030 Requests arriving while busy are neither granted nor rejected; they stay pending.
REQ-031 Last-granted pointer updates on grant; at most one bit set across grant/reject/job_done/job_timeout per cycle.
REQ-032 Earliest re-grant is the cycle after job_done/job_timeout (busy low for at least one cycle).

Reset
REQ-033 On reset: state IDLE; grant, reject, job_done, job_timeout, fifo_wr_en, busy = 0; fifo_wdata = 0; counter = 0; pointer = requester 1, so requester 0 wins the first tie.
REQ-034 Reset mid-job abandons the job with no pulse; it is not retried and the FIFO is not flushed.

Verification
REQ-035 req = 2'b01, sweep, init 32'h1000_0000, cycles 10, step 32'h100, fifo_full = 0 -> grant = 01; next cycle fifo_wr_en with fifo_wdata = 88'h00_1000_0000_000A_0000_0100; sweep_done 50 cycles later -> job_done = 01.
REQ-036 req = 2'b11 held across three jobs -> grant order 01, 10, 01.
REQ-037 Sweep request with cycles = 0 -> reject pulse, no fifo_wr_en, pointer unchanged.
REQ-038 fifo_full high for 7 cycles after grant -> fifo_wr_en asserted once, on the first cycle fifo_full is low.
REQ-039 WATCHDOG_CYCLES = 100, no sweep_done -> job_timeout 100 cycles after the write; separately, PLL job with PLL_DWELL_CYCLES = 20 -> job_done 20 cycles after the write.
REQ-040 Reset in WAIT_SWEEP, then sweep_done pulse -> no job_done, busy = 0, next request granted normally.

Source files
------------

// File: rtl/sweep_scheduler_if.sv
// Requester / FIFO / sweeper signal bundle for the sweep scheduler.
// The slave modport is the scheduler; the master modport drives requests,
// FIFO back-pressure and the sweeper completion pulse.
interface sweep_scheduler_if;
  logic [1:0]  req;
  logic [1:0]  req_mode;
  logic [31:0] req_init_freq0, req_init_freq1;
  logic [15:0] req_cycles0, req_cycles1;
  logic [31:0] req_step0, req_step1;
  logic [1:0]  grant, reject, job_done, job_timeout;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [87:0] fifo_wdata;
  logic        sweep_done;

  modport master (
    output req, req_mode, req_init_freq0, req_init_freq1, req_cycles0, req_cycles1,
           req_step0, req_step1, fifo_full, sweep_done,
    input  grant, reject, job_done, job_timeout, busy, fifo_wr_en, fifo_wdata
  );

  modport slave (
    input  req, req_mode, req_init_freq0, req_init_freq1, req_cycles0, req_cycles1,
           req_step0, req_step1, fifo_full, sweep_done,
    output grant, reject, job_done, job_timeout, busy, fifo_wr_en, fifo_wdata
  );
endinterface

// File: rtl/sweep_scheduler.sv
// Two-requester round-robin scheduler: validates and latches one job at a
// time, writes its packed instruction to the FIFO, then waits for the
// sweeper (with watchdog) or for the PLL dwell time before releasing.
module sweep_scheduler #(
  parameter logic [23:0] WATCHDOG_CYCLES  = 24'd16_000_000,
  parameter logic [23:0] PLL_DWELL_CYCLES = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  sweep_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWEEP, WAIT_PLL} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;          // requester granted most recently
  logic [1:0]  owner_q, owner_d;        // one-hot owner of the job in flight
  logic [87:0] word_q, word_d;          // latched instruction word
  logic [23:0] cnt_q, cnt_d;            // watchdog / dwell counter
  logic [1:0]  grant_q, grant_d, reject_q, reject_d;
  logic [1:0]  done_q, done_d, tmo_q, tmo_d;
  logic        busy_q, busy_d, wr_q, wr_d;
  logic [87:0] wdata_q, wdata_d;

  logic        sel;
  logic [1:0]  sel_oh;
  logic        sel_mode;
  logic [15:0] sel_cycles;
  logic [87:0] sel_word;

  // Round-robin pick and operand mux for the candidate owner
  always_comb begin
    sel        = (bus.req == 2'b11) ? ~last_q : ~bus.req[0];
    sel_oh     = sel ? 2'b10 : 2'b01;
    sel_mode   = bus.req_mode[sel];
    sel_cycles = sel ? bus.req_cycles1 : bus.req_cycles0;
    sel_word   = sel ? {sel_mode, 7'd0, bus.req_init_freq1, bus.req_cycles1, bus.req_step1}
                     : {sel_mode, 7'd0, bus.req_init_freq0, bus.req_cycles0, bus.req_step0};
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    grant_d  = 2'b00;
    reject_d = 2'b00;
    done_d   = 2'b00;
    tmo_d    = 2'b00;
    busy_d   = busy_q;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          if (!sel_mode && sel_cycles == 16'd0) begin
            // zero-length sweep is refused; pointer stays so fairness is unaffected
            reject_d = sel_oh;
          end else begin
            grant_d = sel_oh;
            owner_d = sel_oh;
            last_d  = sel;
            word_d  = sel_word;
            busy_d  = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (!bus.fifo_full) begin
          wr_d    = 1'b1;
          wdata_d = word_q;
          cnt_d   = 24'd0;
          state_d = word_q[87] ? WAIT_PLL : WAIT_SWEEP;
        end
      end
      WAIT_SWEEP: begin
        // completion wins over the watchdog when both land together
        if (bus.sweep_done) begin
          done_d  = owner_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == WATCHDOG_CYCLES - 24'd1) begin
          tmo_d   = owner_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      WAIT_PLL: begin
        if (cnt_q == PLL_DWELL_CYCLES - 24'd1) begin
          done_d  = owner_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any job silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 2'b00;
      word_q   <= '0;
      cnt_q    <= '0;
      grant_q  <= 2'b00;
      reject_q <= 2'b00;
      done_q   <= 2'b00;
      tmo_q    <= 2'b00;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      reject_q <= reject_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.reject      = reject_q;
  assign bus.job_done    = done_q;
  assign bus.job_timeout = tmo_q;
  assign bus.busy        = busy_q;
  assign bus.fifo_wr_en  = wr_q;
  assign bus.fifo_wdata  = wdata_q;
endmodule

// File: tb/tb_sweep_scheduler.sv
// Bench for sweep_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a job-level model.
module tb_sweep_scheduler;
  localparam logic [23:0] WD = 24'd100;
  localparam logic [23:0] PD = 24'd20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  sweep_scheduler_if bus();
  sweep_scheduler #(.WATCHDOG_CYCLES(WD), .PLL_DWELL_CYCLES(PD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // A job is: chosen -> waits for a non-full FIFO slot -> ages k cycles
  // after the write until sweep_done / watchdog (sweep) or dwell (PLL).
  function automatic int pick(input logic [1:0] r, input int last);
    if (r[0] && r[1]) return (last == 0) ? 1 : 0;
    return r[0] ? 0 : 1;
  endfunction

  function automatic logic [87:0] pack_of(input int p);
    logic [87:0] w;
    w = '0;
    w[87] = bus.req_mode[p];
    if (p == 0) begin
      w[79:48] = bus.req_init_freq0; w[47:32] = bus.req_cycles0; w[31:0] = bus.req_step0;
    end else begin
      w[79:48] = bus.req_init_freq1; w[47:32] = bus.req_cycles1; w[31:0] = bus.req_step1;
    end
    return w;
  endfunction

  logic        m_active, m_written;
  int          m_last, m_age;
  logic [1:0]  m_owner;
  logic [87:0] m_word;
  logic [1:0]  e_grant, e_reject, e_done, e_tmo;
  logic        e_busy, e_wr;
  logic [87:0] e_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_written <= 1'b0; m_last <= 1; m_age <= 0;
      m_owner <= 2'b00; m_word <= '0;
      e_grant <= 2'b00; e_reject <= 2'b00; e_done <= 2'b00; e_tmo <= 2'b00;
      e_busy <= 1'b0; e_wr <= 1'b0; e_wdata <= '0;
    end else begin
      e_grant <= 2'b00; e_reject <= 2'b00; e_done <= 2'b00; e_tmo <= 2'b00; e_wr <= 1'b0;
      if (!m_active) begin
        if (bus.req != 2'b00) begin
          if (!pack_of(pick(bus.req, m_last))[87] && pack_of(pick(bus.req, m_last))[47:32] == 16'd0)
            e_reject <= 2'(1 << pick(bus.req, m_last));
          else begin
            e_grant   <= 2'(1 << pick(bus.req, m_last));
            m_owner   <= 2'(1 << pick(bus.req, m_last));
            m_last    <= pick(bus.req, m_last);
            m_word    <= pack_of(pick(bus.req, m_last));
            m_active  <= 1'b1;
            m_written <= 1'b0;
            e_busy    <= 1'b1;
          end
        end
      end else if (!m_written) begin
        if (!bus.fifo_full) begin
          e_wr <= 1'b1; e_wdata <= m_word; m_written <= 1'b1; m_age <= 0;
        end
      end else begin
        m_age <= m_age + 1;
        if (!m_word[87] && bus.sweep_done) begin
          e_done <= m_owner; m_active <= 1'b0; e_busy <= 1'b0;
        end else if (!m_word[87] && m_age + 1 == int'(WD)) begin
          e_tmo <= m_owner; m_active <= 1'b0; e_busy <= 1'b0;
        end else if (m_word[87] && m_age + 1 == int'(PD)) begin
          e_done <= m_owner; m_active <= 1'b0; e_busy <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("grant",       88'(bus.grant),       88'(e_grant));
    chk("reject",      88'(bus.reject),      88'(e_reject));
    chk("job_done",    88'(bus.job_done),    88'(e_done));
    chk("job_timeout", 88'(bus.job_timeout), 88'(e_tmo));
    chk("busy",        88'(bus.busy),        88'(e_busy));
    chk("fifo_wr_en",  88'(bus.fifo_wr_en),  88'(e_wr));
    if (e_wr) chk("fifo_wdata", bus.fifo_wdata, e_wdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit hit(input int which);
    case (which)
      0:       return bus.grant != 2'b00;
      1:       return bus.fifo_wr_en == 1'b1;
      2:       return bus.job_done != 2'b00;
      default: return bus.job_timeout != 2'b00;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!hit(which) && cyc < 300);
    if (!hit(which)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_%s: no event within %0d cycles", name, cyc);
    end
  endtask

  task automatic set_req(input int r, input logic mode, input logic [31:0] f,
                         input logic [15:0] c, input logic [31:0] s);
    bus.req_mode[r] = mode;
    if (r == 0) begin bus.req_init_freq0 = f; bus.req_cycles0 = c; bus.req_step0 = s; end
    else        begin bus.req_init_freq1 = f; bus.req_cycles1 = c; bus.req_step1 = s; end
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // after a grant: wait for the write, then finish the sweep quickly
  task automatic finish_sweep();
    int c;
    wait_sig("wr", 1, c);
    tick(3);
    bus.sweep_done = 1'b1;
    tick(1);
    bus.sweep_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int c, wcount;
    logic [1:0] order [3];
    bus.req = 2'b00; bus.req_mode = 2'b00;
    set_req(0, 1'b0, 32'h0, 16'd0, 32'h0);
    set_req(1, 1'b0, 32'h0, 16'd0, 32'h0);
    bus.fifo_full = 1'b0; bus.sweep_done = 1'b0;
    #1 reset = 1'b1;
    tick(3);
    chk("reset_busy",  88'(bus.busy), 88'(0));
    chk("reset_wdata", bus.fifo_wdata, 88'h0);
    chk("reset_wr",    88'(bus.fifo_wr_en), 88'(0));
    reset = 1'b0;
    tick(1);

    // single sweep job, literal instruction word
    set_req(0, 1'b0, 32'h1000_0000, 16'd10, 32'h100);
    bus.req = 2'b01;
    wait_sig("grant", 0, c);
    chk("t1_grant", 88'(bus.grant), 88'(2'b01));
    bus.req = 2'b00;
    tick(1);
    chk("t1_wr",   88'(bus.fifo_wr_en), 88'(1));
    chk("t1_word", bus.fifo_wdata, 88'h00_1000_0000_000A_0000_0100);
    tick(50);
    bus.sweep_done = 1'b1;
    tick(1);
    bus.sweep_done = 1'b0;
    chk("t1_done", 88'(bus.job_done), 88'(2'b01));
    chk("t1_busy", 88'(bus.busy), 88'(0));

    // fairness from reset with both requesting
    do_reset();
    set_req(1, 1'b0, 32'h2222_0000, 16'd5, 32'h7);
    bus.req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_sig("grant_rr", 0, c);
      order[j] = bus.grant;
      if (j == 2) bus.req = 2'b00;
      finish_sweep();
    end
    chk("rr_0", 88'(order[0]), 88'(2'b01));
    chk("rr_1", 88'(order[1]), 88'(2'b10));
    chk("rr_2", 88'(order[2]), 88'(2'b01));

    // zero-length sweep refused, pointer left alone (requester 1 still wins the tie)
    set_req(1, 1'b0, 32'h3333_0000, 16'd0, 32'h9);
    bus.req = 2'b10;
    tick(1);
    chk("t3_reject", 88'(bus.reject), 88'(2'b10));
    bus.req = 2'b00;
    tick(3);
    chk("t3_no_wr", 88'(bus.fifo_wr_en), 88'(0));
    set_req(1, 1'b0, 32'h3333_0000, 16'd4, 32'h9);
    bus.req = 2'b11;
    wait_sig("grant_ptr", 0, c);
    chk("t3_ptr", 88'(bus.grant), 88'(2'b10));
    bus.req = 2'b00;
    finish_sweep();

    // FIFO back-pressure for 7 cycles after grant
    bus.fifo_full = 1'b1;
    bus.req = 2'b01;
    wait_sig("grant_ff", 0, c);
    bus.req = 2'b00;
    wcount = 0;
    repeat (7) begin tick(1); wcount += int'(bus.fifo_wr_en); end
    bus.fifo_full = 1'b0;
    tick(1);
    chk("t4_first_low", 88'(bus.fifo_wr_en), 88'(1));
    wcount += int'(bus.fifo_wr_en);
    repeat (4) begin tick(1); wcount += int'(bus.fifo_wr_en); end
    chk("t4_count", 88'(wcount), 88'(1));
    bus.sweep_done = 1'b1;
    tick(1);
    bus.sweep_done = 1'b0;

    // watchdog: timeout exactly WD cycles after the write
    bus.req = 2'b01;
    wait_sig("grant_wd", 0, c);
    bus.req = 2'b00;
    wait_sig("wr_wd", 1, c);
    wait_sig("timeout", 3, c);
    chk("t5_wd_cycles", 88'(c), 88'(100));
    chk("t5_wd_owner", 88'(bus.job_timeout), 88'(2'b01));

    // PLL dwell: done exactly PD cycles after the write
    set_req(0, 1'b1, 32'h0ABC_0000, 16'd0, 32'h1);
    bus.req = 2'b01;
    wait_sig("grant_pll", 0, c);
    bus.req = 2'b00;
    wait_sig("wr_pll", 1, c);
    chk("t5_pll_mode_bit", 88'(bus.fifo_wdata[87]), 88'(1));
    wait_sig("pll_done", 2, c);
    chk("t5_pll_cycles", 88'(c), 88'(20));

    // sweep_done on the watchdog's last cycle wins
    set_req(0, 1'b0, 32'h1000_0000, 16'd10, 32'h100);
    bus.req = 2'b01;
    wait_sig("grant_pri", 0, c);
    bus.req = 2'b00;
    wait_sig("wr_pri", 1, c);
    tick(99);
    bus.sweep_done = 1'b1;
    tick(1);
    bus.sweep_done = 1'b0;
    chk("t5_pri_done", 88'(bus.job_done), 88'(2'b01));
    chk("t5_pri_tmo",  88'(bus.job_timeout), 88'(2'b00));

    // reset mid-sweep abandons the job silently
    bus.req = 2'b01;
    wait_sig("grant_rst", 0, c);
    bus.req = 2'b00;
    wait_sig("wr_rst", 1, c);
    tick(5);
    do_reset();
    bus.sweep_done = 1'b1;
    tick(1);
    bus.sweep_done = 1'b0;
    chk("t6_no_done", 88'(bus.job_done), 88'(2'b00));
    chk("t6_busy",    88'(bus.busy), 88'(0));
    bus.req = 2'b01;
    wait_sig("grant_after_rst", 0, c);
    chk("t6_regrant", 88'(bus.grant), 88'(2'b01));
    bus.req = 2'b00;
    finish_sweep();

    // randomized traffic; odd segments withhold sweep_done to exercise the watchdog
    for (int i = 0; i < 1800; i++) begin
      tick(1);
      bus.req      = 2'($urandom_range(0, 3));
      bus.req_mode = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      set_req(0, bus.req_mode[0], $urandom,
              ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)), $urandom);
      set_req(1, bus.req_mode[1], $urandom,
              ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)), $urandom);
      bus.fifo_full  = ($urandom_range(0, 2) == 0);
      bus.sweep_done = ((i / 300) % 2 == 0) ? ($urandom_range(0, 24) == 0) : 1'b0;
    end
    bus.req = 2'b00; bus.sweep_done = 1'b0; bus.fifo_full = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
